// File: rtl/raster_timing_gen.sv
// Raster timing generator: walks active/porch/sync regions on both axes and emits x/y, de, syncs, eol/ovf.
// Optional frame counter (frame_cnt, frame_cnt_clr) is built only when RASTER_FRAME_CNT_EN is defined.
module raster_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW      = $clog2(H_TOTAL),
  localparam int YW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
`ifdef RASTER_FRAME_CNT_EN
  input  logic          frame_cnt_clr,
  output logic [15:0]   frame_cnt,
`endif
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic          eol,
  output logic          ovf
);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_param_err
    $error("raster_timing_gen: every timing parameter must be >= 1");
  end

  localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
  localparam logic [XW-1:0] X_ACT    = XW'(H_ACTIVE);
  localparam logic [YW-1:0] Y_ACT    = YW'(V_ACTIVE);
  localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic          eol_q, eol_d, ovf_q, ovf_d;

  // de/hsync/vsync are decoded from the next position so they land with the x/y they describe.
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    eol_d = 1'b0;
    ovf_d = 1'b0;
    if (en) begin
      if (x_q == X_LAST) begin
        x_d   = '0;
        eol_d = 1'b1;
        if (y_q == Y_LAST) begin
          y_d   = '0;
          ovf_d = 1'b1;
        end else begin
          y_d = y_q + YW'(1);
        end
      end else begin
        x_d = x_q + XW'(1);
      end
    end
    de_d = (x_d < X_ACT) && (y_d < Y_ACT);
    hs_d = ((x_d >= HS_START) && (x_d < HS_END)) ? HS_POL : ~HS_POL;
    vs_d = ((y_d >= VS_START) && (y_d < VS_END)) ? VS_POL : ~VS_POL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      de_q  <= 1'b1;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      eol_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      de_q  <= de_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      eol_q <= eol_d;
      ovf_q <= ovf_d;
    end
  end

`ifdef RASTER_FRAME_CNT_EN
  logic [15:0] fcnt_q, fcnt_d;

  // Clear wins over a coincident frame wrap.
  always_comb begin
    fcnt_d = fcnt_q;
    if (frame_cnt_clr)  fcnt_d = '0;
    else if (ovf_d)     fcnt_d = fcnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fcnt_q <= '0;
    else        fcnt_q <= fcnt_d;
  end

  assign frame_cnt = fcnt_q;
`endif

  assign x     = x_q;
  assign y     = y_q;
  assign de    = de_q;
  assign hsync = hs_q;
  assign vsync = vs_q;
  assign eol   = eol_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_raster_timing_gen.sv
// Scoreboard bench for raster_timing_gen on a small 8x6 raster; model tracks a linear pixel index.
module tb_raster_timing_gen;
  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam bit HSP = 1'b0, VSP = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [2:0] x, y;
  logic       de, hsync, vsync, eol, ovf;
`ifdef RASTER_FRAME_CNT_EN
  logic        frame_cnt_clr = 1'b0;
  logic [15:0] frame_cnt;
`endif

  raster_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(HSP), .VS_POL(VSP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
`ifdef RASTER_FRAME_CNT_EN
    .frame_cnt_clr(frame_cnt_clr), .frame_cnt(frame_cnt),
`endif
    .x(x), .y(y), .de(de), .hsync(hsync), .vsync(vsync), .eol(eol), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  x, y;
    logic        de, hs, vs, eol, ovf;
    logic [15:0] fc;
  } obs_t;

  obs_t        q[$];
  int          n_cmp = 0, n_bad = 0;
  int          p = 0;
  bit          meol = 0, movf = 0;
  logic [15:0] mfc = '0;

  function automatic obs_t model_obs();
    obs_t e;
    int   xx = p % HT;
    int   yy = p / HT;
    e.x   = xx[2:0];
    e.y   = yy[2:0];
    e.de  = (xx < HA) && (yy < VA);
    e.hs  = (xx >= HA + HF && xx < HA + HF + HS) ? HSP : !HSP;
    e.vs  = (yy >= VA + VF && yy < VA + VF + VS) ? VSP : !VSP;
    e.eol = meol;
    e.ovf = movf;
    e.fc  = mfc;
    return e;
  endfunction

  function automatic obs_t dut_obs();
    obs_t g;
    g.x = x; g.y = y; g.de = de; g.hs = hsync; g.vs = vsync;
    g.eol = eol; g.ovf = ovf;
`ifdef RASTER_FRAME_CNT_EN
    g.fc = frame_cnt;
`else
    g.fc = '0;
`endif
    return g;
  endfunction

  task automatic check(input string name, input obs_t g, input obs_t e);
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s @%0t: got x=%0d y=%0d de=%b hs=%b vs=%b eol=%b ovf=%b fc=%0d, want x=%0d y=%0d de=%b hs=%b vs=%b eol=%b ovf=%b fc=%0d",
               name, $time, g.x, g.y, g.de, g.hs, g.vs, g.eol, g.ovf, g.fc,
               e.x, e.y, e.de, e.hs, e.vs, e.eol, e.ovf, e.fc);
    end
  endtask

  // Monitor: the DUT presents a new observation every cycle; compare it mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) check("cycle", dut_obs(), q.pop_front());
  end

  task automatic model_reset();
    p = 0; meol = 0; movf = 0; mfc = '0;
  endtask

  // One clock edge: advance the reference using the inputs present at the edge, queue the expectation.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      meol = 0;
      movf = 0;
      if (en) begin
        p    = (p + 1) % FT;
        meol = (p % HT) == 0;
        movf = (p == 0);
      end
`ifdef RASTER_FRAME_CNT_EN
      if (frame_cnt_clr) mfc = '0;
      else if (movf)     mfc = mfc + 16'd1;
`endif
    end
    q.push_back(model_obs());
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 model_reset();
    check("reset_state", dut_obs(), model_obs());
    tick(); tick();
    rst_n = 1'b1;
    en    = 1'b1;

    // Free-running frames with en high: covers x cycling, sync windows, eol/ovf coincidence.
    repeat (2 * FT + 5) tick();

    // Hold at end of line: en 1,0,0,1 while x=7.
    for (int i = 0; i < 2 * HT && (p % HT) != HT - 1; i++) tick();
    en = 1'b0; tick(); tick();
    en = 1'b1; tick(); tick();

    // Asynchronous reset mid-cycle at x=3, y=4.
    for (int i = 0; i < 2 * FT && p != 4 * HT + 3; i++) tick();
    #2 rst_n = 1'b0;
    #1 model_reset();
    q.delete();
    q.push_back(model_obs());
    check("async_reset", dut_obs(), model_obs());
    tick();
    #3 rst_n = 1'b1;
    repeat (HT + 3) tick();

`ifdef RASTER_FRAME_CNT_EN
    // Three frames from a cleared counter, then a clear coinciding with the frame wrap.
    frame_cnt_clr = 1'b1; tick(); frame_cnt_clr = 1'b0;
    for (int i = 0; i < 2 * FT && p != 0; i++) tick();
    repeat (3 * FT) tick();
    for (int i = 0; i < 2 * FT && p != FT - 1; i++) tick();
    frame_cnt_clr = 1'b1; tick(); frame_cnt_clr = 1'b0;
    repeat (4) tick();
`endif

    // Randomized enable (and occasional clear) over many frames.
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 3) != 0);
`ifdef RASTER_FRAME_CNT_EN
      frame_cnt_clr = ($urandom_range(0, 199) == 0);
`endif
      tick();
    end
    en = 1'b0;
`ifdef RASTER_FRAME_CNT_EN
    frame_cnt_clr = 1'b0;
`endif

    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/raster_timing_gen.md
Name: raster_timing_gen

Overview:
- Parametrised raster timing generator; successor to the fixed 10-bit pixel X/Y counter used by the rainbow test.
- Walks a full video frame (active, front porch, sync, back porch, both axes) and produces pixel coordinates, data-enable, HSYNC/VSYNC and line/frame strobes.
- Sits between the pixel-clock domain and the pattern/colour generator; feeds the display PHY directly.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- HS_POL, 0, HSYNC asserted level (0 = active-low)
- VS_POL, 0, VSYNC asserted level (0 = active-low)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  pixel advance enable; counters step only when high
- x  out  XW  horizontal count, XW = $clog2(H_TOTAL)
- y  out  YW  vertical count, YW = $clog2(V_TOTAL)
- de  out  1  high when x < H_ACTIVE and y < V_ACTIVE
- hsync  out  1  horizontal sync at HS_POL level during the sync window
- vsync  out  1  vertical sync at VS_POL level during the sync window
- eol  out  1  one-clock pulse: line wrapped this step
- ovf  out  1  one-clock pulse: frame wrapped this step (start of frame)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Elaboration error if any timing parameter < 1.
- Reset (asynchronous assert, synchronous release) takes effect immediately, including mid-frame: x=0, y=0, de=1, hsync=~HS_POL, vsync=~VS_POL, eol=0, ovf=0.
- All outputs are flop outputs. The registered next-state decode keeps de, hsync and vsync aligned to the same cycle as the x/y they describe, with no combinational path from en to outputs.
- On a clk edge with en=1:
  - x<H_TOTAL-1: x+1.
  - x=H_TOTAL-1: x=0, eol=1 next cycle.
  - y increments only when x wraps.
  - y=V_TOTAL-1 and x wraps: y=0, ovf=1 and eol=1 in the same next cycle.
- en=0: x, y, de, hsync and vsync hold. eol/ovf still deassert after one cycle (pulses are never stretched).
- hsync asserted iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, on every line including blanking lines.
- vsync asserted iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC. Changes only in the cycle where x=0.
- Arithmetic is unsigned. x and y never reach H_TOTAL or V_TOTAL. No wrap through 2^XW.

Optional Feature:
- Macro RASTER_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt, out, 16 bits, reset 0.
  - Increments in the same cycle ovf asserts; wraps 0xFFFF -> 0.
  - Adds input frame_cnt_clr, in, 1, synchronous clear.
  - frame_cnt_clr takes priority over a simultaneous increment (result is 0).
- Undefined: neither port exists, and no counter logic is generated.

Test Plan:
- Small config H=4/1/2/1 (H_TOTAL=8), V=3/1/1/1 (V_TOTAL=6), HS_POL=VS_POL=0, en held high:
  - x cycles 0..7.
  - hsync low exactly at x=5,6.
  - de high for x 0..3 on y 0..2 only.
  - eol pulses once every 8 clocks.
- Same config, run 48 clocks:
  - ovf high once, coinciding with x=0,y=0.
  - vsync low only for y=4.
  - eol and ovf coincide at frame wrap.
- en toggled 1,0,0,1 at x=7:
  - x holds 7 while en=0.
  - eol pulses for exactly one clk after the wrap step, not during the hold.
- rst_n pulsed low asynchronously (mid-clock) at x=3,y=4:
  - Outputs go to reset values before the next edge.
  - After release, counting resumes from (0,0).
- Default 640x480 config:
  - 800*525 = 420000 enabled clocks between consecutive ovf pulses.
  - hsync low for 96 clocks per line.
  - vsync low for 2*800 clocks.
- RASTER_FRAME_CNT_EN defined:
  - frame_cnt reaches 3 after 3 frames.
  - frame_cnt_clr asserted on an ovf cycle leaves frame_cnt=0.
